// File: rtl/bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one bus slave among several masters.
// Grants one requester, steers its address/ctrl to the slave, tracks wait/burst, then releases.
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int BUS_WIDTH   = 32,
  parameter int CTRL_WIDTH  = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  master_bus,
  input  logic [NUM_MASTERS*CTRL_WIDTH-1:0] master_ctrl,
  input  logic [CTRL_WIDTH-1:0]             slave_ctrl,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic [BUS_WIDTH-1:0]              bus_to_slave,
  output logic [CTRL_WIDTH-1:0]             ctrl_to_slave,
  output logic                              ack,
  output logic                              busy,
  output logic                              xfer_done,
  output logic                              timeout_err
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int LAT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    LAT     = 3'd2,
    DATA    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [3:0]       beat_cnt;
  logic [3:0]       last_beat;
  logic [LAT_W-1:0] lat_cnt;
  logic             seen_wait;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  // Burst code to index of the final beat; codes with bit 2 set are single-beat.
  function automatic logic [3:0] burst_last(input logic [2:0] code);
    case (code)
      3'b001:  burst_last = 4'd1;
      3'b010:  burst_last = 4'd3;
      3'b011:  burst_last = 4'd7;
      default: burst_last = 4'd0;
    endcase
  endfunction

  // Search upward from the round-robin pointer with wrap; first set request wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_MASTERS;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  // NOTE: every output is given a value before the loop so no latch is inferred
  // when no grant bit is set.
  always_comb begin
    bus_to_slave  = '0;
    ctrl_to_slave = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        bus_to_slave  = master_bus[i*BUS_WIDTH +: BUS_WIDTH];
        ctrl_to_slave = master_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end
  end

  assign busy = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      ack         <= 1'b0;
      xfer_done   <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      winner      <= '0;
      beat_cnt    <= '0;
      last_beat   <= '0;
      lat_cnt     <= '0;
      seen_wait   <= 1'b0;
    end else begin
      xfer_done   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant  <= NUM_MASTERS'(1) << pick_idx;
            ack    <= 1'b1;
            winner <= pick_idx;
            state  <= ADDR;
          end
        end
        ADDR: begin
          last_beat <= burst_last(ctrl_to_slave[4:2]);
          seen_wait <= 1'b0;
          lat_cnt   <= '0;
          beat_cnt  <= '0;
          state     <= LAT;
        end
        LAT: begin
          if (slave_ctrl[0]) seen_wait <= 1'b1;
          // A completed wait handshake takes priority over the timeout on the same cycle.
          if (seen_wait && !slave_ctrl[0]) begin
            beat_cnt <= '0;
            state    <= DATA;
          end else if (lat_cnt == LAT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            ack         <= 1'b0;
            grant       <= '0;
            state       <= RELEASE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        DATA: begin
          if (beat_cnt == last_beat) begin
            xfer_done <= 1'b1;
            ack       <= 1'b0;
            grant     <= '0;
            state     <= RELEASE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        RELEASE: begin
          rr_ptr <= (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_ack_has_grant: assert property (@(posedge clk) disable iff (rst) ack |-> (grant != '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: rotation, burst lengths, wait handshake, timeout and reset.
module tb_bus_arbiter;

  localparam int NM = 4;
  localparam int BW = 32;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   req;
  logic [NM*BW-1:0] master_bus;
  logic [NM*CW-1:0] master_ctrl;
  logic [CW-1:0]   slave_ctrl;
  logic [NM-1:0]   grant;
  logic [BW-1:0]   bus_to_slave;
  logic [CW-1:0]   ctrl_to_slave;
  logic            ack, busy, xfer_done, timeout_err;

  logic [BW-1:0]   mbus  [NM];
  logic [CW-1:0]   mctrl [NM];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always_comb begin
    master_bus  = '0;
    master_ctrl = '0;
    for (int i = 0; i < NM; i++) begin
      master_bus[i*BW +: BW]  = mbus[i];
      master_ctrl[i*CW +: CW] = mctrl[i];
    end
  end

  bus_arbiter #(
    .NUM_MASTERS(NM),
    .BUS_WIDTH  (BW),
    .CTRL_WIDTH (CW),
    .TIMEOUT    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .master_bus   (master_bus),
    .master_ctrl  (master_ctrl),
    .slave_ctrl   (slave_ctrl),
    .grant        (grant),
    .bus_to_slave (bus_to_slave),
    .ctrl_to_slave(ctrl_to_slave),
    .ack          (ack),
    .busy         (busy),
    .xfer_done    (xfer_done),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Step negedges until ack rises; returns how many ack-low samples preceded it.
  task automatic wait_ack(output int low);
    low = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) return;
      low++;
    end
    check("wait_ack_timeout", 1'b0, 1'b1);
  endtask

  // Called at the ADDR-phase negedge. Slave holds wait high for lat cycles (forever if stuck),
  // then counts ack-high samples until the RELEASE sample, where the pulses are captured.
  task automatic xfer(input int lat, input bit stuck, output int cyc,
                      output logic done, output logic to, output logic [NM-1:0] g_rel);
    cyc = 0; done = 1'b0; to = 1'b0; g_rel = 'x;
    slave_ctrl = 8'h01;
    repeat (lat) @(negedge clk);
    if (!stuck) slave_ctrl = 8'h00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack) cyc++;
      else begin
        done  = xfer_done;
        to    = timeout_err;
        g_rel = grant;
        break;
      end
    end
    slave_ctrl = 8'h00;
  endtask

  initial begin
    int low, cyc;
    logic done, to;
    logic [NM-1:0] g;
    logic [NM-1:0] exp_rot [5];
    exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low, cyc;
    logic done, to;
    logic [NM-1:0] g;
    logic [NM-1:0] exp_rot [5];
    exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; req = '0; slave_ctrl = '0;
    for (int i = 0; i < NM; i++) begin
      mbus[i]  = 32'hA5A5_0000 | 32'(i * 16'h1111);
      mctrl[i] = 8'h02;
    end
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 4'b0000);
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_xfer_done", xfer_done, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_bus_zero", bus_to_slave, 32'h0);
    check("rst_ctrl_zero", ctrl_to_slave, 8'h0);
    rst = 1'b0;

    // 1: single request, 4-beat burst, latency 4
    mctrl[2] = 8'h0A;
    req = 4'b0100;
    wait_ack(low);
    req = '0;
    check("t1_latency", low, 0);
    check("t1_grant", grant, 4'b0100);
    check("t1_busy", busy, 1'b1);
    check("t1_bus_mux", bus_to_slave, 32'hA5A5_2222);
    check("t1_ctrl_mux", ctrl_to_slave, 8'h0A);
    xfer(4, 1'b0, cyc, done, to, g);
    check("t1_data_cycles", cyc, 4);
    check("t1_xfer_done", done, 1'b1);
    check("t1_no_timeout", to, 1'b0);
    check("t1_release_grant", g, 4'b0000);
    @(negedge clk);
    check("t1_done_pulse_len", xfer_done, 1'b0);
    check("t1_idle_busy", busy, 1'b0);

    // 2: all masters request from a freshly reset pointer, single-beat bursts
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mctrl[2] = 8'h02;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(low);
      if (n == 4) req = '0;
      if (n > 0) check($sformatf("t2_gap%0d", n), low + 1, 2);
      check($sformatf("t2_grant%0d", n), grant, exp_rot[n]);
      xfer(2, 1'b0, cyc, done, to, g);
      check($sformatf("t2_cycles%0d", n), cyc, 1);
    end

    // 5: burst 011 gives 8 beats, burst 111 gives 1 beat
    mctrl[0] = 8'h0E;
    req = 4'b0001;
    wait_ack(low);
    req = '0;
    check("t5a_grant", grant, 4'b0001);
    xfer(3, 1'b0, cyc, done, to, g);
    check("t5a_data_cycles", cyc, 8);
    check("t5a_done", done, 1'b1);
    mctrl[0] = 8'h1E;
    req = 4'b0001;
    wait_ack(low);
    req = '0;
    xfer(3, 1'b0, cyc, done, to, g);
    check("t5b_data_cycles", cyc, 1);

    // 3: slave wait stuck high, TIMEOUT=8
    mctrl[0] = 8'h02;
    req = 4'b0011;
    wait_ack(low);
    check("t3_grant", grant, 4'b0010);
    xfer(0, 1'b1, cyc, done, to, g);
    check("t3_lat_cycles", cyc, 8);
    check("t3_timeout", to, 1'b1);
    check("t3_no_done", done, 1'b0);
    check("t3_release_grant", g, 4'b0000);
    @(negedge clk);
    check("t3_timeout_pulse_len", timeout_err, 1'b0);
    check("t3_idle_ack", ack, 1'b0);
    wait_ack(low);
    req = '0;
    check("t3_next_grant", grant, 4'b0001);
    xfer(3, 1'b0, cyc, done, to, g);
    check("t3_next_cycles", cyc, 1);

    // 6: master drops req during LAT; transaction still completes and pointer advances
    mctrl[2] = 8'h0A;
    req = 4'b0100;
    wait_ack(low);
    check("t6_grant", grant, 4'b0100);
    slave_ctrl = 8'h01;
    @(negedge clk);
    req = '0;
    xfer(3, 1'b0, cyc, done, to, g);
    check("t6_data_cycles", cyc, 4);
    check("t6_done", done, 1'b1);
    req = 4'b1111;
    wait_ack(low);
    req = '0;
    check("t6_ptr_advanced", grant, 4'b1000);
    xfer(2, 1'b0, cyc, done, to, g);

    // 4: reset during DATA of master 3
    mctrl[3] = 8'h0E;
    req = 4'b1000;
    wait_ack(low);
    req = '0;
    check("t4_grant", grant, 4'b1000);
    slave_ctrl = 8'h01;
    repeat (3) @(negedge clk);
    slave_ctrl = 8'h00;
    repeat (3) @(negedge clk);
    check("t4_in_data_ack", ack, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_grant", grant, 4'b0000);
    check("t4_rst_ack", ack, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_bus", bus_to_slave, 32'h0);
    rst = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    req = '0;
    check("t4_post_grant", grant, 4'b0010);
    check("t4_post_ack", ack, 1'b1);
    xfer(2, 1'b0, cyc, done, to, g);
    check("t4_post_cycles", cyc, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
